// File: rtl/mem_rsp_if.sv
// Byte-serial CPU bus plus the host-facing TX/RX byte streams of mem_rsp.
interface mem_rsp_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_wn;
    logic [7:0]  cpu_rn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    // CPU / host side
    modport master (
        output cpu_a, cpu_wr, cpu_wn,
        input  cpu_rn,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );

    // Memory responder side
    modport slave (
        input  cpu_a, cpu_wr, cpu_wn,
        output cpu_rn,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/mem_rsp.sv
// Memory-side responder: byte RAM with 1-cycle reads, plus a small I/O window
// holding a TX byte FIFO, a 1-entry RX holding register and a sticky halt flag.
module mem_rsp #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned TXQ_DEPTH = 16,
    parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
    input  logic      clk,
    input  logic      rst,
    mem_rsp_if.slave  bus,
    output logic      halt
);
    localparam int unsigned RAM_BYTES = 1 << ADDR_W;
    localparam int unsigned PTR_W     = $clog2(TXQ_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    logic [7:0]        mem [RAM_BYTES];
    logic [7:0]        txq [TXQ_DEPTH];
    logic [PTR_W-1:0]  tx_head, tx_tail;
    logic [CNT_W-1:0]  tx_count;
    logic              ovf;
    logic              rx_full;
    logic [7:0]        rx_buf;
    logic [7:0]        ram_q;
    logic [7:0]        io_q;
    logic              rd_ram;

    logic [ADDR_W-1:0] ram_a;
    logic [31:0]       io_off;
    logic              is_io;
    logic              io_wr_tx, io_wr_halt, io_rd_rx, io_rd_st;
    logic              tx_full, tx_empty, tx_push, tx_pop, ovf_set;
    logic              rx_load, rx_pop;
    logic [7:0]        io_next;

    assign ram_a  = bus.cpu_a[ADDR_W-1:0];
    assign io_off = bus.cpu_a - IO_BASE;
    assign is_io  = (bus.cpu_a >= IO_BASE) && (io_off < 32'd16);

    assign io_wr_tx   = is_io &&  bus.cpu_wr && (io_off == 32'd0);
    assign io_wr_halt = is_io &&  bus.cpu_wr && (io_off == 32'd4);
    assign io_rd_rx   = is_io && !bus.cpu_wr && (io_off == 32'd0);
    assign io_rd_st   = is_io && !bus.cpu_wr && (io_off == 32'd8);

    assign tx_full  = (tx_count == CNT_W'(TXQ_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_pop   = bus.tx_valid && bus.tx_ready;
    // A push into a full FIFO still fits when the head leaves at the same edge.
    assign tx_push  = io_wr_tx && (!tx_full || tx_pop);
    assign ovf_set  = io_wr_tx && tx_full && !tx_pop;

    assign bus.tx_data  = txq[tx_head];
    assign bus.tx_valid = !tx_empty;

    assign rx_load      = bus.rx_valid && !rx_full;
    assign rx_pop       = io_rd_rx && rx_full;
    assign bus.rx_ready = !rx_full;

    // RAM array: write on store, registered read of the old byte every cycle
    always_ff @(posedge clk) begin
        if (!is_io && bus.cpu_wr) begin
            mem[ram_a] <= bus.cpu_wn;
        end
        ram_q <= mem[ram_a];
    end

    // I/O read data for the current address
    always_comb begin
        io_next = 8'h00;
        if (rx_pop) begin
            io_next = rx_buf;
        end else if (io_rd_st) begin
            io_next = {6'b0, ovf, tx_empty};
        end
    end

    // Read-return select; RAM data stays unreset, the select and I/O byte carry
    // the reset so cpu_rn reads zero immediately on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ram <= 1'b0;
            io_q   <= '0;
        end else begin
            rd_ram <= !is_io;
            io_q   <= io_next;
        end
    end

    assign bus.cpu_rn = rd_ram ? ram_q : io_q;

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) begin
            txq[tx_tail] <= bus.cpu_wn;
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_head  <= '0;
            tx_tail  <= '0;
            tx_count <= '0;
            ovf      <= 1'b0;
        end else begin
            if (tx_push) tx_tail <= tx_tail + PTR_W'(1);
            if (tx_pop)  tx_head <= tx_head + PTR_W'(1);
            if (tx_push && !tx_pop) begin
                tx_count <= tx_count + CNT_W'(1);
            end else if (tx_pop && !tx_push) begin
                tx_count <= tx_count - CNT_W'(1);
            end
            if (ovf_set) ovf <= 1'b1;
        end
    end

    // RX holding register: host loads when empty, CPU read of offset 0 empties it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_full <= 1'b0;
            rx_buf  <= '0;
        end else if (rx_load) begin
            rx_full <= 1'b1;
            rx_buf  <= bus.rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    // Sticky halt flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt <= 1'b0;
        end else if (io_wr_halt) begin
            halt <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_rsp.sv
// Scoreboard bench for mem_rsp: drivers push expected read/TX bytes into
// queues, monitors pop and compare when the DUT presents data.
module tb_mem_rsp;
    localparam logic [31:0] IO = 32'h0003_0000;

    logic clk;
    logic rst;
    logic halt;
    mem_rsp_if bus ();

    mem_rsp #(.ADDR_W(17), .TXQ_DEPTH(16), .IO_BASE(IO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .halt (halt)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    logic       rd_flag = 1'b0;
    logic       rd_d    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read monitor: a read presented at the last rising edge returns now
    always @(posedge clk) rd_d <= rd_flag;

    always @(negedge clk) begin
        logic [7:0] e;
        if (rd_d) begin
            if (rd_q.size() == 0) begin
                check("rd_q_underflow", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                check("cpu_rn", {24'b0, bus.cpu_rn}, {24'b0, e});
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) begin
                check("tx_q_underflow", 32'd1, 32'd0);
            end else begin
                e = tx_q.pop_front();
                check("tx_data", {24'b0, bus.tx_data}, {24'b0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.cpu_a  = IO + 32'd12;
        bus.cpu_wr = 1'b0;
        bus.cpu_wn = 8'h00;
        rd_flag    = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.cpu_a  = a;
        bus.cpu_wr = 1'b1;
        bus.cpu_wn = d;
        rd_flag    = 1'b0;
        step();
    endtask

    task automatic wrc(input logic [31:0] a, input logic [7:0] d, input logic [7:0] exp);
        bus.cpu_a  = a;
        bus.cpu_wr = 1'b1;
        bus.cpu_wn = d;
        rd_q.push_back(exp);
        rd_flag    = 1'b1;
        step();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        bus.cpu_a  = a;
        bus.cpu_wr = 1'b0;
        bus.cpu_wn = 8'h00;
        rd_q.push_back(exp);
        rd_flag    = 1'b1;
        step();
    endtask

    initial begin
        rst          = 1'b0;
        set_idle();
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        #12;
        check("rst_cpu_rn", {24'b0, bus.cpu_rn}, 32'h00);
        check("rst_halt", {31'b0, halt}, 32'd0);
        check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        rst = 1'b1;
        step();
        check("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd1);

        // RAM: write/read, aliasing, read-before-write, back-to-back
        wr(32'h0000_0100, 8'hA5);
        rd(32'h0000_0100, 8'hA5);
        wr(32'h0002_0100, 8'h5A);
        rd(32'h0000_0100, 8'h5A);
        rd(32'h0002_0100, 8'h5A);
        wrc(32'h0000_0100, 8'h77, 8'h5A);
        wr(32'h0000_0101, 8'h11);
        rd(32'h0000_0100, 8'h77);
        rd(32'h0000_0101, 8'h11);
        set_idle();
        step();

        // TX: "Hi" drained immediately
        bus.tx_ready = 1'b1;
        tx_q.push_back(8'h48);
        wr(IO, 8'h48);
        tx_q.push_back(8'h69);
        wr(IO, 8'h69);
        set_idle();
        repeat (3) step();
        check("tx_drained", {31'b0, bus.tx_valid}, 32'd0);
        rd(IO + 32'd8, 8'h01);
        set_idle();
        step();

        // TX overflow: 17 pushes, last dropped
        bus.tx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) tx_q.push_back(8'(i));
            wr(IO, 8'(i));
        end
        rd(IO + 32'd8, 8'h02);
        // Push while full with a pop at the same edge: accepted, no drop
        bus.tx_ready = 1'b1;
        tx_q.push_back(8'hAA);
        wr(IO, 8'hAA);
        bus.tx_ready = 1'b0;
        rd(IO + 32'd8, 8'h02);
        set_idle();
        step();
        // Exactly 16 entries remain
        bus.tx_ready = 1'b1;
        repeat (15) step();
        check("tx_full_count_15", {31'b0, bus.tx_valid}, 32'd1);
        step();
        check("tx_full_count_16", {31'b0, bus.tx_valid}, 32'd0);
        bus.tx_ready = 1'b0;
        rd(IO + 32'd8, 8'h03);
        set_idle();
        step();

        // RX holding register
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        step();
        check("rx_ready_full", {31'b0, bus.rx_ready}, 32'd0);
        bus.rx_data = 8'h55;
        step();
        check("rx_hold", {31'b0, bus.rx_ready}, 32'd0);
        rd(IO, 8'h3C);
        set_idle();
        step();
        bus.rx_valid = 1'b0;
        check("rx_reload", {31'b0, bus.rx_ready}, 32'd0);
        rd(IO, 8'h55);
        set_idle();
        step();
        check("rx_empty", {31'b0, bus.rx_ready}, 32'd1);
        rd(IO, 8'h00);
        set_idle();
        step();

        // Halt sticky across RAM traffic
        wr(IO + 32'd4, 8'h00);
        check("halt_set", {31'b0, halt}, 32'd1);
        wr(32'h0000_0200, 8'h33);
        rd(32'h0000_0200, 8'h33);
        set_idle();
        step();
        check("halt_sticky", {31'b0, halt}, 32'd1);

        // Reset mid-run with TX bytes queued
        wr(IO, 8'h01);
        wr(IO, 8'h02);
        rd(32'h0000_0100, 8'h77);
        set_idle();
        #5;
        check("pre_rst_tx_valid", {31'b0, bus.tx_valid}, 32'd1);
        rst = 1'b0;
        tx_q.delete();
        #1;
        check("async_rst_cpu_rn", {24'b0, bus.cpu_rn}, 32'h00);
        check("async_rst_halt", {31'b0, halt}, 32'd0);
        check("async_rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        #10;
        rst = 1'b1;
        step();
        rd(IO + 32'd8, 8'h01);
        set_idle();
        repeat (2) step();

        check("rd_q_drained", rd_q.size(), 32'd0);
        check("tx_q_drained", tx_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_rsp.md
Name: mem_rsp

Overview:
- Memory-side responder for the CPU's byte-serial bus (address, write strobe, write byte, read byte), i.e. the far end of the memory controller's external port.
- Holds a byte RAM and answers reads with one-cycle latency.
- Decodes a small memory-mapped I/O window: TX byte FIFO toward a host sink, 1-entry RX holding register from a host source, sticky halt flag.
- Instantiated beside the CPU top in the simulation/FPGA wrapper.

Parameters:
ADDR_W, 17, RAM is 2^ADDR_W bytes; low ADDR_W address bits index it
TXQ_DEPTH, 16, TX FIFO entries (power of two, >=2)
IO_BASE, 32'h0003_0000, base of I/O window

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cpu_a  in  32  byte address, driven every cycle
cpu_wr  in  1  1 = write cpu_wn this cycle, 0 = read
cpu_wn  in  8  write byte
cpu_rn  out  8  read byte, registered
tx_data  out  8  TX FIFO head byte
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  sink accepts head this cycle
rx_data  in  8  byte from host
rx_valid  in  1  host offers rx_data
rx_ready  out  1  RX holding register empty
halt  out  1  sticky program-finished flag

Behaviour:
- Reset (rst=0, async):
  - cpu_rn=0, halt=0, ovf=0.
  - TX FIFO empty (tx_valid=0, pointers/count 0).
  - RX register empty (rx_ready=1 once rst=1).
  - RAM contents not reset.
- Decode: cpu_a in [IO_BASE, IO_BASE+15] is I/O. Everything else is RAM at cpu_a[ADDR_W-1:0]; higher bits alias.
- RAM read (cpu_wr=0): cpu_rn = mem[a] on the next edge. Latency exactly 1 cycle. Back-to-back addresses yield back-to-back bytes.
- RAM write (cpu_wr=1): mem[a] <= cpu_wn at the edge. cpu_rn gets the old byte (read-before-write).
- I/O writes:
  - IO_BASE+0: push cpu_wn into TX FIFO. If full and no pop this cycle, drop the byte and set sticky ovf.
  - IO_BASE+4: halt<=1 (sticky until reset).
  - Other offsets: ignored.
- I/O reads:
  - IO_BASE+0: cpu_rn <= RX byte if RX full, else 8'h00. If full, RX empties at the same edge.
  - IO_BASE+8: cpu_rn <= {6'b0, ovf, tx_empty}.
  - Other offsets: return 8'h00.
  - The CPU presents each I/O load address for exactly one cycle. Reads have side effects; re-presenting an address pops again.
- TX FIFO:
  - Circular buffer, count width log2(TXQ_DEPTH)+1.
  - tx_data = head; pop when tx_valid && tx_ready.
  - Simultaneous push and pop: both happen and count is unchanged, including when full (push accepted, no ovf) and when empty+push (no pop, since tx_valid=0).
  - Pointers wrap modulo TXQ_DEPTH.
- RX: rx_ready = RX empty. Load rx_data when rx_valid && rx_ready. A CPU pop and a host load never coincide because rx_ready=0 while full; the host byte loads on the next cycle after the pop.
- halt: does not stop RAM/FIFO activity. TX keeps draining after halt.
- Reset mid-transfer: any queued TX/RX bytes are discarded.

Test Plan:
- Write 0xA5 to 0x00100, read 0x00100 next cycle -> cpu_rn=0xA5 one cycle after read address; write/read 0x20100 with ADDR_W=17 aliases 0x00100.
- Write 'H','i' to 0x30000, tx_ready=1 -> tx_valid two cycles, tx_data 0x48 then 0x69, then tx_valid=0; status read 0x30008 -> 0x01.
- tx_ready=0, push 17 bytes (0x00..0x10) -> first 16 queued, 0x10 dropped, status read -> 0x02; then push with tx_ready=1 while full -> accepted, count stays 16, ovf stays set.
- rx_valid=1 rx_data=0x3C -> rx_ready drops next cycle; read 0x30000 -> cpu_rn=0x3C, rx_ready=1 after; second read -> 0x00.
- Write any byte to 0x30004 -> halt=1 next cycle, persists across RAM traffic; assert rst=0 mid-run -> halt=0, tx_valid=0, cpu_rn=0 immediately (async).
